// File: rtl/spike_arbiter.sv
// Round-robin arbiter that serialises per-channel spikes onto a shared synapse
// datapath, with timestep draining and per-step handshake accounting.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | spikes land in pending; events are offered round-robin
// DRAIN  | tick seen; finish pending, park new spikes in next_pending
module spike_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] spike_in,
  input  logic                  tick_in,
  output logic                  evt_valid,
  output logic [ID_WIDTH-1:0]   evt_id,
  input  logic                  evt_ready,
  output logic                  step_done,
  output logic [15:0]           evt_count,
  output logic                  overflow,
  output logic                  tick_overrun
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                r_state;
  logic [NUM_INPUTS-1:0] r_pending;
  logic [NUM_INPUTS-1:0] r_next_pending;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [15:0]           r_step_cnt;

  logic                  w_handshake;
  logic                  w_load;
  logic                  w_exit;
  logic                  w_found_any;
  logic                  w_found_hi;
  logic [ID_WIDTH-1:0]   w_idx_any;
  logic [ID_WIDTH-1:0]   w_idx_hi;
  logic [ID_WIDTH-1:0]   w_sel_idx;
  logic [ID_WIDTH-1:0]   w_rr_nxt;
  logic [NUM_INPUTS-1:0] w_clr;
  logic [NUM_INPUTS-1:0] w_pending_nxt;
  logic [NUM_INPUTS-1:0] w_next_pending_nxt;
  logic                  w_ovf_hit;
  logic [15:0]           w_cnt_inc;

  assign w_handshake = evt_valid & evt_ready;
  assign w_load      = ~evt_valid | evt_ready;
  // Exit as soon as the output register is about to be empty, so a final
  // handshake in the same cycle is still credited to the ending step.
  assign w_exit      = (r_state == ST_DRAIN) && (r_pending == '0) && w_load;

  // Lowest set bit at/above the pointer wins; otherwise wrap to the lowest set bit.
  always_comb begin
    w_found_any = 1'b0;
    w_found_hi  = 1'b0;
    w_idx_any   = '0;
    w_idx_hi    = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_found_any = 1'b1;
        w_idx_any   = ID_WIDTH'(i);
        if (ID_WIDTH'(i) >= r_rr_ptr) begin
          w_found_hi = 1'b1;
          w_idx_hi   = ID_WIDTH'(i);
        end
      end
    end
  end

  assign w_sel_idx = w_found_hi ? w_idx_hi : w_idx_any;
  assign w_rr_nxt  = (w_sel_idx == ID_WIDTH'(NUM_INPUTS - 1)) ? '0
                                                              : w_sel_idx + ID_WIDTH'(1);
  assign w_clr     = (w_load && w_found_any)
                     ? ({{(NUM_INPUTS-1){1'b0}}, 1'b1} << w_sel_idx) : '0;

  assign w_cnt_inc = (w_handshake && (r_step_cnt != 16'hFFFF)) ? r_step_cnt + 16'd1
                                                               : r_step_cnt;

  always_comb begin
    w_pending_nxt      = r_pending;
    w_next_pending_nxt = r_next_pending;
    w_ovf_hit          = 1'b0;
    if (r_state == ST_RUN) begin
      w_pending_nxt = (r_pending & ~w_clr) | spike_in;
      w_ovf_hit     = |(spike_in & r_pending & ~w_clr);
    end else if (w_exit) begin
      // Parked spikes and same-edge spikes both become the new step's work.
      w_pending_nxt      = r_next_pending | spike_in;
      w_next_pending_nxt = '0;
      w_ovf_hit          = |(spike_in & r_next_pending);
    end else begin
      w_pending_nxt      = r_pending & ~w_clr;
      w_next_pending_nxt = r_next_pending | spike_in;
      w_ovf_hit          = |(spike_in & r_next_pending);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_pending      <= '0;
      r_next_pending <= '0;
      r_rr_ptr       <= '0;
      r_step_cnt     <= '0;
      evt_valid      <= 1'b0;
      evt_id         <= '0;
      step_done      <= 1'b0;
      evt_count      <= '0;
      overflow       <= 1'b0;
      tick_overrun   <= 1'b0;
    end else begin
      step_done      <= 1'b0;
      r_pending      <= w_pending_nxt;
      r_next_pending <= w_next_pending_nxt;
      r_step_cnt     <= w_exit ? 16'd0 : w_cnt_inc;
      if (w_ovf_hit) begin
        overflow <= 1'b1;
      end
      if (w_load) begin
        if (w_found_any) begin
          evt_valid <= 1'b1;
          evt_id    <= w_sel_idx;
          r_rr_ptr  <= w_rr_nxt;
        end else begin
          evt_valid <= 1'b0;
        end
      end
      case (r_state)
        ST_RUN: begin
          if (tick_in) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (tick_in) begin
            tick_overrun <= 1'b1;
          end
          if (w_exit) begin
            r_state   <= ST_RUN;
            step_done <= 1'b1;
            evt_count <= w_cnt_inc;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule
